// File: rtl/led_pkg.sv
// led_pkg: shared types and defaults for the WS2812 LED output path.
// Holds the TX FSM states, default timing and colour expansion.
package led_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BIT,
      GAP
   } tx_state_t;

   localparam int N_LED_D  = 8;
   localparam int MEAN_W_D = 4;
   localparam int T_BIT_D  = 63;
   localparam int T0H_D    = 20;
   localparam int T1H_D    = 40;
   localparam int T_RST_D  = 2500;

   typedef struct packed {
      logic [7:0] g;
      logic [7:0] r;
      logic [7:0] b;
   } grb_t;

   // Replicates the w-bit mean (right-aligned in m) to fill 8 bits.
   function automatic logic [7:0] expand_mean(
      input logic [7:0] m,
      input int         w
   );
      logic [7:0] c;
      c = '0;
      for (int i = 0; i < 8; i++)
         c[3'(7 - i)] = m[3'(w - 1 - (i % w))];
      return c;
   endfunction

endpackage

// File: rtl/ws2812_bit_gen.sv
// ws2812_bit_gen: one WS2812 bit cell, high T0H/T1H then low to T_BIT.
// dout is registered and reflects the count for the coming cycle.
module ws2812_bit_gen #(
   parameter int T_BIT = 63,
   parameter int T0H   = 20,
   parameter int T1H   = 40
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic bit_start,
   input  logic bit_val,
   output logic dout,
   output logic bit_last
);

   localparam int CW = $clog2(T_BIT);
   localparam logic [CW-1:0] LAST = CW'(T_BIT - 1);
   localparam logic [CW-1:0] HI0  = CW'(T0H);
   localparam logic [CW-1:0] HI1  = CW'(T1H);

   logic [CW-1:0] bit_cnt;
   logic [CW-1:0] cnt_nx;
   logic [CW-1:0] hi_time;

   // Next position in the bit cell and the high time of this bit.
   always_comb begin
      cnt_nx  = bit_start ? '0 : bit_cnt + 1'b1;
      hi_time = bit_val ? HI1 : HI0;
   end

   // Cell counter and the registered line level.
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt <= '0;
         dout    <= 1'b0;
      end else begin
         bit_cnt <= run ? cnt_nx : '0;
         dout    <= run && (cnt_nx < hi_time);
      end
   end

   assign bit_last = (bit_cnt == LAST);

endmodule

// File: rtl/ws2812_tx.sv
// ws2812_tx: snapshots per-zone RGB means and serialises them as GRB
// WS2812 frames, with one pending frame and a latch gap after each.
module ws2812_tx
   import led_pkg::*;
#(
   parameter int N_LED  = N_LED_D,
   parameter int MEAN_W = MEAN_W_D,
   parameter int T_BIT  = T_BIT_D,
   parameter int T0H    = T0H_D,
   parameter int T1H    = T1H_D,
   parameter int T_RST  = T_RST_D
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start_i,
   input  logic [N_LED-1:0][MEAN_W-1:0]   MeanR,
   input  logic [N_LED-1:0][MEAN_W-1:0]   MeanG,
   input  logic [N_LED-1:0][MEAN_W-1:0]   MeanB,
   output logic                           led_dout,
   output logic                           busy,
   output logic                           done_o
);

   localparam int LW = (N_LED > 1) ? $clog2(N_LED) : 1;
   localparam int RW = (T_RST > 1) ? $clog2(T_RST) : 1;
   localparam logic [4:0]    LAST_BIT = 5'd23;
   localparam logic [LW-1:0] LAST_LED = LW'(N_LED - 1);
   localparam logic [RW-1:0] LAST_RST = RW'(T_RST - 1);

   typedef logic [N_LED-1:0][MEAN_W-1:0] means_t;

   tx_state_t     state, state_nx;
   logic [4:0]    bit_idx, bit_nx;
   logic [LW-1:0] led_idx, led_nx;
   logic [RW-1:0] rst_cnt, rst_nx;

   means_t act_r, act_g, act_b;
   means_t pend_r, pend_g, pend_b;
   means_t src_r, src_g, src_b;
   means_t nx_r, nx_g, nx_b;
   logic   pending;
   logic   take_in;
   logic   load_act;

   logic gen_start, gen_run, gen_last, bit_val;
   logic busy_nx, done_nx;
   grb_t word;

   // Next-state, counter advance and bit selection for the coming cycle.
   always_comb begin
      take_in   = (state == IDLE) || start_i;
      src_r     = take_in ? MeanR : pend_r;
      src_g     = take_in ? MeanG : pend_g;
      src_b     = take_in ? MeanB : pend_b;
      state_nx  = state;
      bit_nx    = bit_idx;
      led_nx    = led_idx;
      rst_nx    = rst_cnt;
      load_act  = 1'b0;
      gen_start = 1'b0;
      unique case (state)
         IDLE: begin
            if (start_i) begin
               state_nx  = BIT;
               load_act  = 1'b1;
               gen_start = 1'b1;
               bit_nx    = '0;
               led_nx    = '0;
            end
         end
         BIT: begin
            if (gen_last) begin
               if (bit_idx != LAST_BIT) begin
                  bit_nx    = bit_idx + 1'b1;
                  gen_start = 1'b1;
               end else if (led_idx != LAST_LED) begin
                  bit_nx    = '0;
                  led_nx    = led_idx + 1'b1;
                  gen_start = 1'b1;
               end else begin
                  state_nx = GAP;
                  rst_nx   = '0;
               end
            end
         end
         GAP: begin
            if (rst_cnt == LAST_RST) begin
               if (pending || start_i) begin
                  state_nx  = BIT;
                  load_act  = 1'b1;
                  gen_start = 1'b1;
                  bit_nx    = '0;
                  led_nx    = '0;
               end else begin
                  state_nx = IDLE;
               end
            end else begin
               rst_nx = rst_cnt + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
      nx_r    = load_act ? src_r : act_r;
      nx_g    = load_act ? src_g : act_g;
      nx_b    = load_act ? src_b : act_b;
      word    = '0;
      word.g  = expand_mean(8'(nx_g[led_nx]), MEAN_W);
      word.r  = expand_mean(8'(nx_r[led_nx]), MEAN_W);
      word.b  = expand_mean(8'(nx_b[led_nx]), MEAN_W);
      bit_val = word[LAST_BIT - bit_nx];
      gen_run = (state_nx == BIT);
      busy_nx = (state_nx != IDLE);
      done_nx = (state_nx == GAP) && (rst_nx == LAST_RST);
   end

   // FSM state, frame indices and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         bit_idx <= '0;
         led_idx <= '0;
         rst_cnt <= '0;
         busy    <= 1'b0;
         done_o  <= 1'b0;
      end else begin
         state   <= state_nx;
         bit_idx <= bit_nx;
         led_idx <= led_nx;
         rst_cnt <= rst_nx;
         busy    <= busy_nx;
         done_o  <= done_nx;
      end
   end

   // A start outside IDLE parks one frame; loading it clears the flag.
   always_ff @(posedge clk) begin
      if (rst)
         pending <= 1'b0;
      else if (load_act)
         pending <= 1'b0;
      else if (start_i && (state != IDLE))
         pending <= 1'b1;
   end

   // Active and pending snapshots; newest start wins the pending slot.
   always_ff @(posedge clk) begin
      if (load_act) begin
         act_r <= src_r;
         act_g <= src_g;
         act_b <= src_b;
      end
      if (start_i && (state != IDLE) && !load_act) begin
         pend_r <= MeanR;
         pend_g <= MeanG;
         pend_b <= MeanB;
      end
   end

   ws2812_bit_gen #(
      .T_BIT (T_BIT),
      .T0H   (T0H),
      .T1H   (T1H)
   ) u_bit_gen (
      .clk       (clk),
      .rst       (rst),
      .run       (gen_run),
      .bit_start (gen_start),
      .bit_val   (bit_val),
      .dout      (led_dout),
      .bit_last  (gen_last)
   );

endmodule

// File: tb/tb_ws2812_tx.sv
// tb_ws2812_tx: directed bench for the WS2812 serialiser.
// Expected frames are queued at start and checked as the line decodes.
`timescale 1ns/1ps
module tb_ws2812_tx;

   localparam int N_LED  = 8;
   localparam int MEAN_W = 4;
   localparam int T_BIT  = 63;
   localparam int T0H    = 20;
   localparam int T1H    = 40;
   localparam int T_RST  = 2500;
   localparam int NB     = 24 * N_LED;
   localparam int FRAME  = NB * T_BIT + T_RST;

   logic clk = 1'b0;
   logic rst;
   logic start_i;
   logic [N_LED-1:0][MEAN_W-1:0] mr, mg, mb;
   logic led_dout, busy, done_o;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int busy_acc    = 0;
   int busy_fall   = 0;
   int done_idle   = 0;
   logic busy_q    = 1'b0;
   logic [NB-1:0] exp_q[$];

   ws2812_tx #(
      .N_LED  (N_LED),
      .MEAN_W (MEAN_W),
      .T_BIT  (T_BIT),
      .T0H    (T0H),
      .T1H    (T1H),
      .T_RST  (T_RST)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start_i  (start_i),
      .MeanR    (mr),
      .MeanG    (mg),
      .MeanB    (mb),
      .led_dout (led_dout),
      .busy     (busy),
      .done_o   (done_o)
   );

   always #5 clk = ~clk;

   // Cycle count, busy accounting and busy-fall / idle-done tallies.
   always @(posedge clk) begin
      cyc      <= cyc + 1;
      busy_acc <= busy_acc + (busy ? 1 : 0);
      busy_q   <= busy;
      if (busy_q && !busy)
         busy_fall <= busy_fall + 1;
      if (done_o && !busy)
         done_idle <= done_idle + 1;
   end

   function automatic logic [NB-1:0] mk(
      input logic [N_LED-1:0][MEAN_W-1:0] r,
      input logic [N_LED-1:0][MEAN_W-1:0] g,
      input logic [N_LED-1:0][MEAN_W-1:0] b
   );
      logic [NB-1:0] f;
      f = '0;
      for (int i = 0; i < N_LED; i++)
         f[8'(NB - 1 - 24 * i) -: 24] =
            {g[3'(i)], g[3'(i)], r[3'(i)], r[3'(i)],
             b[3'(i)], b[3'(i)]};
      return f;
   endfunction

   task automatic chk(input string tag,
                      input logic [NB-1:0] obs,
                      input logic [NB-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_i(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic fire();
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic rand_means();
      for (int i = 0; i < N_LED; i++) begin
         mr[3'(i)] = 4'($urandom_range(15, 0));
         mg[3'(i)] = 4'($urandom_range(15, 0));
         mb[3'(i)] = 4'($urandom_range(15, 0));
      end
   endtask

   // Decodes n bit cells from the first high cycle; flags bad shapes.
   task automatic rx_bits(input int n,
                          output logic [NB-1:0] data,
                          output int bad,
                          output int t_rise);
      int w;
      int h;
      logic lo;
      data   = '0;
      bad    = 0;
      w      = 0;
      t_rise = -1;
      while (!led_dout && w < 2 * FRAME) begin
         @(negedge clk);
         w++;
      end
      if (!led_dout) begin
         bad = 1;
         return;
      end
      t_rise = cyc;
      for (int k = 0; k < n; k++) begin
         h  = 0;
         lo = 1'b0;
         for (int c = 0; c < T_BIT; c++) begin
            if (k != 0 || c != 0)
               @(negedge clk);
            if (led_dout) begin
               if (lo)
                  bad++;
               h++;
            end else begin
               if (c == 0)
                  bad++;
               lo = 1'b1;
            end
         end
         if (h == T1H)
            data[8'(NB - 1 - k)] = 1'b1;
         else if (h != T0H)
            bad++;
      end
   endtask

   // Runs to the done_o cycle, counting any high line cycles on the way.
   task automatic wait_done(output int t_done, output int hi);
      int w;
      w      = 0;
      hi     = 0;
      t_done = -1;
      do begin
         @(negedge clk);
         w++;
         if (led_dout)
            hi++;
      end while (!done_o && w < 2 * T_RST);
      if (done_o)
         t_done = cyc;
   endtask

   initial begin
      int c0, tr, tr2, td, td2, bad, bad2, hi, hi2, a0, f0;
      logic [NB-1:0] got, got2, ex, ex2;

      rst     = 1'b1;
      start_i = 1'b0;
      mr      = '0;
      mg      = '0;
      mb      = '0;
      repeat (4) @(negedge clk);
      chk_i("rst_led", 32'(led_dout), 0);
      chk_i("rst_busy", 32'(busy), 0);
      chk_i("rst_done", 32'(done_o), 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // All-zero frame: shape, latency, frame length, busy length.
      exp_q.push_back(mk(mr, mg, mb));
      c0 = cyc;
      a0 = busy_acc;
      chk_i("t1_pre_led", 32'(led_dout), 0);
      fire();
      chk_i("t1_lat_led", 32'(led_dout), 1);
      chk_i("t1_lat_busy", 32'(busy), 1);
      rx_bits(NB, got, bad, tr);
      chk_i("t1_shape", 32'(bad), 0);
      ex = exp_q.pop_front();
      chk("t1_frame", got, ex);
      wait_done(td, hi);
      chk_i("t1_gap_hi", 32'(hi), 0);
      chk_i("t1_done_t", 32'(td - c0), FRAME);
      @(negedge clk);
      chk_i("t1_busy_end", 32'(busy), 0);
      repeat (3) @(negedge clk);
      chk_i("t1_busy_len", 32'(busy_acc - a0), FRAME);

      // Two starts mid-frame: active frame intact, newest queued.
      rand_means();
      exp_q.push_back(mk(mr, mg, mb));
      fire();
      fork
         begin
            repeat (1000) @(negedge clk);
            rand_means();
            exp_q.push_back(mk(mr, mg, mb));
            fire();
            repeat (2000) @(negedge clk);
            rand_means();
            exp_q[exp_q.size() - 1] = mk(mr, mg, mb);
            fire();
         end
         begin
            f0 = busy_fall;
            rx_bits(NB, got, bad, tr);
            chk_i("t3_shape1", 32'(bad), 0);
            ex = exp_q.pop_front();
            chk("t3_frame1", got, ex);
            wait_done(td, hi);
            rx_bits(NB, got2, bad2, tr2);
            chk_i("t3_back2back", 32'(tr2), 32'(td + 1));
            chk_i("t3_shape2", 32'(bad2), 0);
            ex2 = exp_q.pop_front();
            chk("t3_frame2", got2, ex2);
            wait_done(td2, hi2);
            chk_i("t3_gap_hi", 32'(hi + hi2), 0);
            chk_i("t3_busy_kept", 32'(busy_fall), 32'(f0));
         end
      join
      repeat (3) @(negedge clk);
      chk_i("t3_idle_busy", 32'(busy), 0);

      // Known pattern on LED 0, then a start on the done_o cycle.
      mr    = '0;
      mg    = '0;
      mb    = '0;
      mg[0] = 4'hF;
      mr[0] = 4'hA;
      mb[0] = 4'h0;
      exp_q.push_back(mk(mr, mg, mb));
      c0 = cyc;
      fire();
      rx_bits(NB, got, bad, tr);
      chk_i("t2_shape", 32'(bad), 0);
      ex = exp_q.pop_front();
      chk("t2_frame", got, ex);
      chk_i("t2_led0", 32'(got[NB-1 -: 24]), 32'h00FFAA00);
      chk("t2_rest", {24'h0, got[NB-25:0]}, '0);
      wait_done(td, hi);
      chk_i("t4_done_t", 32'(td - c0), FRAME);
      chk_i("t4_done", 32'(done_o), 1);
      rand_means();
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      chk_i("t4_led", 32'(led_dout), 1);
      chk_i("t4_busy", 32'(busy), 1);
      chk_i("t4_done_off", 32'(done_o), 0);

      // Reset at bit 50 with a frame pending.
      repeat (50 * T_BIT - 1) @(negedge clk);
      rand_means();
      fire();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_i("t5_led", 32'(led_dout), 0);
      chk_i("t5_busy", 32'(busy), 0);
      chk_i("t5_done", 32'(done_o), 0);
      hi = 0;
      bad = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (led_dout)
            hi++;
         if (busy)
            bad++;
      end
      chk_i("t5_quiet_led", 32'(hi), 0);
      chk_i("t5_quiet_busy", 32'(bad), 0);
      rand_means();
      exp_q.push_back(mk(mr, mg, mb));
      fire();
      rx_bits(24, got, bad, tr);
      chk_i("t5_shape", 32'(bad), 0);
      ex = exp_q.pop_front();
      chk_i("t5_led0", 32'(got[NB-1 -: 24]), 32'(ex[NB-1 -: 24]));
      chk_i("idle_done", 32'(done_idle), 0);

      rst = 1'b1;
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
